// File: rtl/wave_render.sv
// -----------------------------------------------------------------------------
// wave_render
//   Turns the waveform sample read back from the 512x8 capture RAM into RGB565
//   pixels for the VGA output. The trace is drawn as connected vertical
//   segments between adjacent columns. A dotted graticule, a dashed trigger
//   level marker and a one-pixel window frame are drawn underneath it. The
//   de/hsync/vsync inputs are delayed so that they stay aligned with pix_rgb.
//
//   Ports
//     clk_dp       pixel clock, all logic on the rising edge
//     rst_dp       asynchronous active-high reset
//     xpos_dp      current pixel column (also the RAM read address source)
//     ypos_dp      current pixel row
//     de_in        active-video qualifier for xpos_dp/ypos_dp
//     hs_in/vs_in  sync inputs aligned with xpos_dp
//     ad_vga_data  RAM sample for column xpos_dp, valid RAM_LAT cycles later
//     pix_rgb      RGB565 pixel, RAM_LAT+1 cycles after xpos_dp/ypos_dp
//     de_out       de_in delayed to match pix_rgb
//     hs_out/vs_out  sync outputs delayed to match pix_rgb
// -----------------------------------------------------------------------------
module wave_render #(
    parameter int          RAM_LAT  = 2,
    parameter logic [11:0] X_START  = 12'd44,
    parameter logic [11:0] WIN_W    = 12'd512,
    parameter logic [11:0] Y_START  = 12'd72,
    parameter logic [11:0] WIN_H    = 12'd256,
    parameter logic [11:0] GRID_X   = 12'd64,
    parameter logic [11:0] GRID_Y   = 12'd32,
    parameter logic [7:0]  TRIG_LVL = 8'd128,
    parameter logic [15:0] C_TRACE  = 16'hFFE0,
    parameter logic [15:0] C_TRIG   = 16'hF800,
    parameter logic [15:0] C_GRID   = 16'h4208,
    parameter logic [15:0] C_FRAME  = 16'hFFFF,
    parameter logic [15:0] C_BG     = 16'h0000
) (
    input  logic        clk_dp,
    input  logic        rst_dp,
    input  logic [11:0] xpos_dp,
    input  logic [11:0] ypos_dp,
    input  logic        de_in,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic [7:0]  ad_vga_data,
    output logic [15:0] pix_rgb,
    output logic        de_out,
    output logic        hs_out,
    output logic        vs_out
);

    localparam logic [11:0] X_END    = X_START + WIN_W;
    localparam logic [11:0] Y_END    = Y_START + WIN_H;
    localparam logic [11:0] FX_L     = X_START - 12'd1;
    localparam logic [11:0] FY_T     = Y_START - 12'd1;
    localparam logic [11:0] GX_MASK  = GRID_X - 12'd1;
    localparam logic [11:0] GY_MASK  = GRID_Y - 12'd1;
    localparam logic [11:0] TRIG_ROW = Y_START + {4'd0, 8'hFF - TRIG_LVL};

    logic [11:0] r_x_p  [RAM_LAT];
    logic [11:0] r_y_p  [RAM_LAT];
    logic        r_de_p [RAM_LAT];
    logic        r_hs_p [RAM_LAT];
    logic        r_vs_p [RAM_LAT];
    logic [11:0] r_prev_row;

    logic [11:0] w_x;
    logic [11:0] w_y;
    logic        w_de;
    logic        w_x_in;
    logic        w_in_win;
    logic [11:0] w_cur_row;
    logic [11:0] w_lo;
    logic [11:0] w_hi;
    logic [11:0] w_gx;
    logic [11:0] w_gy;
    logic        w_trace;
    logic        w_trig;
    logic        w_grid;
    logic        w_frame;
    logic [15:0] w_color;

    // Stages p0..p(RAM_LAT-1): carry position and syncs until the sample arrives
    always_ff @(posedge clk_dp or posedge rst_dp) begin
        if (rst_dp) begin
            for (int i = 0; i < RAM_LAT; i++) begin
                r_x_p[i]  <= '0;
                r_y_p[i]  <= '0;
                r_de_p[i] <= 1'b0;
                r_hs_p[i] <= 1'b0;
                r_vs_p[i] <= 1'b0;
            end
        end else begin
            r_x_p[0]  <= xpos_dp;
            r_y_p[0]  <= ypos_dp;
            r_de_p[0] <= de_in;
            r_hs_p[0] <= hs_in;
            r_vs_p[0] <= vs_in;
            for (int i = 1; i < RAM_LAT; i++) begin
                r_x_p[i]  <= r_x_p[i-1];
                r_y_p[i]  <= r_y_p[i-1];
                r_de_p[i] <= r_de_p[i-1];
                r_hs_p[i] <= r_hs_p[i-1];
                r_vs_p[i] <= r_vs_p[i-1];
            end
        end
    end

    assign w_x  = r_x_p[RAM_LAT-1];
    assign w_y  = r_y_p[RAM_LAT-1];
    assign w_de = r_de_p[RAM_LAT-1];

    assign w_x_in   = (w_x >= X_START) && (w_x < X_END);
    assign w_in_win = w_x_in && (w_y >= Y_START) && (w_y < Y_END);

    // Full-scale sample sits on the top window row, zero on the bottom row
    assign w_cur_row = Y_START + {4'd0, 8'hFF - ad_vga_data};

    // The first column has no left neighbour, so it draws a single dot
    always_comb begin
        w_lo = w_cur_row;
        w_hi = w_cur_row;
        if (w_x != X_START) begin
            w_lo = (r_prev_row < w_cur_row) ? r_prev_row : w_cur_row;
            w_hi = (r_prev_row < w_cur_row) ? w_cur_row  : r_prev_row;
        end
    end

    assign w_gx = w_x - X_START;
    assign w_gy = w_y - Y_START;

    assign w_trace = w_in_win && (w_y >= w_lo) && (w_y <= w_hi);
    assign w_trig  = w_in_win && (w_y == TRIG_ROW) && !w_x[2];
    // Vertical lines are dotted along y, horizontal lines dotted along x
    assign w_grid  = w_in_win &&
                     ((((w_gx & GX_MASK) == 12'd0) && (w_y[1:0] == 2'b00)) ||
                      (((w_gy & GY_MASK) == 12'd0) && (w_x[1:0] == 2'b00)));
    assign w_frame = (((w_x == FX_L) || (w_x == X_END)) && (w_y >= FY_T) && (w_y <= Y_END)) ||
                     (((w_y == FY_T) || (w_y == Y_END)) && (w_x >= FX_L) && (w_x <= X_END));

    always_comb begin
        w_color = C_BG;
        if (w_trace) begin
            w_color = C_TRACE;
        end else if (w_trig) begin
            w_color = C_TRIG;
        end else if (w_grid) begin
            w_color = C_GRID;
        end else if (w_frame) begin
            w_color = C_FRAME;
        end
        if (!w_de) begin
            w_color = '0;
        end
    end

    // Output stage: pixel, syncs and previous trace row
    always_ff @(posedge clk_dp or posedge rst_dp) begin
        if (rst_dp) begin
            pix_rgb    <= '0;
            de_out     <= 1'b0;
            hs_out     <= 1'b0;
            vs_out     <= 1'b0;
            r_prev_row <= '0;
        end else begin
            pix_rgb <= w_color;
            de_out  <= w_de;
            hs_out  <= r_hs_p[RAM_LAT-1];
            vs_out  <= r_vs_p[RAM_LAT-1];
            if (w_x_in) begin
                r_prev_row <= w_cur_row;
            end
        end
    end

endmodule
